// File: rtl/alu_operand_collector.sv
// ALU operand collector.
// Gathers opa/opb, which may arrive in different cycles, together with a
// locked cmd/mode/cin. It then presents one complete operation on a
// valid/ready output. A two-operand command whose second operand does not
// arrive within TIMEOUT_CYCLES enabled cycles is issued with out_err set.
module alu_operand_collector #(
  parameter int DATA_WIDTH     = 8,
  parameter int CMD_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 16,
  parameter logic [2**CMD_WIDTH-1:0] TWO_OP_ARITH = 16'h070F,
  parameter logic [2**CMD_WIDTH-1:0] TWO_OP_LOGIC = 16'h003F
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic                  mode,
  input  logic                  cin,
  input  logic [CMD_WIDTH-1:0]  cmd,
  input  logic [1:0]            inp_valid,
  input  logic [DATA_WIDTH-1:0] opa,
  input  logic [DATA_WIDTH-1:0] opb,
  output logic                  in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_opa,
  output logic [DATA_WIDTH-1:0] out_opb,
  output logic [CMD_WIDTH-1:0]  out_cmd,
  output logic                  out_mode,
  output logic                  out_cin,
  output logic [1:0]            out_inp_valid,
  output logic                  out_err
);

  // Counter is wide enough to hold TIMEOUT_CYCLES-1 even when it is 1.
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_ISSUE = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;

  // Look up whether a command needs both operands in the given mode.
  function automatic logic need_both(input logic m, input logic [CMD_WIDTH-1:0] c);
    need_both = m ? TWO_OP_ARITH[c] : TWO_OP_LOGIC[c];
  endfunction

  // Collection FSM. All outputs are registered. While collecting, the
  // captured fields live directly in the out_* registers, so an operand
  // that was never flagged valid reads as zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      wait_cnt      <= '0;
      in_ready      <= 1'b1;
      out_valid     <= 1'b0;
      out_opa       <= '0;
      out_opb       <= '0;
      out_cmd       <= '0;
      out_mode      <= 1'b0;
      out_cin       <= 1'b0;
      out_inp_valid <= 2'b00;
      out_err       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ce && (inp_valid != 2'b00)) begin
            out_cmd       <= cmd;
            out_mode      <= mode;
            out_cin       <= cin;
            out_opa       <= inp_valid[0] ? opa : '0;
            out_opb       <= inp_valid[1] ? opb : '0;
            out_inp_valid <= inp_valid;
            out_err       <= 1'b0;
            if (!need_both(mode, cmd) || (inp_valid == 2'b11)) begin
              state     <= S_ISSUE;
              out_valid <= 1'b1;
              in_ready  <= 1'b0;
            end else begin
              state    <= S_WAIT;
              wait_cnt <= '0;
            end
          end
        end

        // Exactly one operand bit is outstanding here. Only that operand is
        // sampled. Completion is checked before the timeout, so an operand
        // that arrives on the last window edge still wins.
        S_WAIT: begin
          if (ce) begin
            if ((inp_valid & ~out_inp_valid) != 2'b00) begin
              if (!out_inp_valid[0]) out_opa <= opa;
              else                   out_opb <= opb;
              out_inp_valid <= 2'b11;
              out_err       <= 1'b0;
              state         <= S_ISSUE;
              out_valid     <= 1'b1;
              in_ready      <= 1'b0;
            end else if (wait_cnt == CNT_LAST) begin
              out_err   <= 1'b1;
              state     <= S_ISSUE;
              out_valid <= 1'b1;
              in_ready  <= 1'b0;
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end
        end

        // The consumer may drain the operation even while ce is low.
        S_ISSUE: begin
          if (out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end

        default: begin
          state     <= S_IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule
